// File: rtl/mem_read_arbiter.sv
// Arbitrates fetch (F) and load (L) reads onto one pipelined memory read port,
// tracks in-flight reads with an in-order tag pipeline and routes responses back.
module mem_read_arbiter #(
  parameter int unsigned ADDR_W     = 61,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  input  logic              l_req_valid,
  input  logic [ADDR_W-1:0] l_req_addr,
  output logic              l_req_ready,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] l_rsp_data,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned QUIET_W = 3;
  localparam logic [CNT_W-1:0]   STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [QUIET_W-1:0] QUIET_INIT = QUIET_W'(LATENCY);

  typedef struct packed {
    logic valid;
    logic src;     // 0 = fetch, 1 = load
    logic killed;
  } tag_t;

  tag_t               tag_q [LATENCY];
  tag_t               tag_d [LATENCY];
  tag_t               out_tag;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [QUIET_W-1:0] quiet_q, quiet_d;
  logic               err_q, err_d;
  logic               f_win, f_grant, l_grant, rsp_hit;

  // L wins by default; F wins when L is idle or F has starved; flush blocks F only.
  always_comb begin
    f_win   = f_req_valid && !flush && ((starve_q == STARVE_LIM) || !l_req_valid);
    f_grant = rst_n && f_win;
    l_grant = rst_n && l_req_valid && !f_win;
  end

  assign f_req_ready   = f_grant;
  assign l_req_ready   = l_grant;
  assign mem_req_valid = f_grant || l_grant;
  assign mem_req_addr  = f_grant ? f_req_addr : (l_grant ? l_req_addr : '0);

  // A flush in the response cycle also drops a fetch response still at the output stage.
  assign out_tag     = tag_q[LATENCY-1];
  assign rsp_hit     = rst_n && mem_rsp_valid && out_tag.valid;
  assign l_rsp_valid = rsp_hit && out_tag.src;
  assign f_rsp_valid = rsp_hit && !out_tag.src && !out_tag.killed && !flush;
  assign l_rsp_data  = l_rsp_valid ? mem_rsp_data : '0;
  assign f_rsp_data  = f_rsp_valid ? mem_rsp_data : '0;
  assign err         = err_q;

  always_comb begin : tag_next
    tag_d[0] = '{valid: mem_req_valid, src: l_grant, killed: 1'b0};
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
      if (flush && tag_q[i-1].valid && !tag_q[i-1].src) begin
        tag_d[i].killed = 1'b1;
      end
    end
  end

  always_comb begin : busy_or
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

  always_comb begin : starve_next
    starve_d = starve_q;
    if (!flush) begin
      if (!f_req_valid || f_grant) begin
        starve_d = '0;
      end else if (starve_q < STARVE_LIM) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  // Quiet window hides responses to reads issued before the last reset.
  always_comb begin : err_next
    quiet_d = (quiet_q == '0) ? '0 : quiet_q - QUIET_W'(1);
    err_d   = err_q || ((quiet_q == '0) && (mem_rsp_valid != out_tag.valid));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      starve_q <= '0;
      quiet_q  <= QUIET_INIT;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
      starve_q <= starve_d;
      quiet_q  <= quiet_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: transaction-level reference model with in-flight
// read queue, a fixed-latency memory responder, and directed plus random scenarios.
module tb_mem_read_arbiter;

  localparam int unsigned AW  = 61;
  localparam int unsigned DW  = 64;
  localparam int          LAT = 2;
  localparam int          SM  = 3;

  logic          clk = 1'b0;
  logic          rst_n, flush, f_req_valid, l_req_valid, mem_rsp_valid;
  logic [AW-1:0] f_req_addr, l_req_addr;
  logic [DW-1:0] mem_rsp_data;
  logic          f_req_ready, f_rsp_valid, l_req_ready, l_rsp_valid;
  logic          mem_req_valid, busy, err;
  logic [DW-1:0] f_rsp_data, l_rsp_data;
  logic [AW-1:0] mem_req_addr;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .l_req_valid(l_req_valid), .l_req_addr(l_req_addr), .l_req_ready(l_req_ready),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {bit src; logic [AW-1:0] addr; int due; bit killed;} rd_t;
  typedef struct {int due; logic [AW-1:0] addr;} mrsp_t;
  rd_t   inflight[$];
  mrsp_t env_q[$];
  int    starve = 0;
  int    quiet = LAT;
  bit    m_err = 1'b0;

  bit            e_f_ready, e_l_ready, e_mem_valid, e_f_rsp, e_l_rsp, e_busy, due_here, env_used;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_f_data, e_l_data;
  bit            cur_fv, cur_lv, cur_fl;
  logic [AW-1:0] cur_fa, cur_la;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a[28:0], 3'b110, ~a[31:0]};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'({$urandom, $urandom});
  endfunction

  // Drive one cycle of stimulus, compute expectations, move to the sample point.
  task automatic tick(input bit fv, input logic [AW-1:0] fa, input bit lv,
                      input logic [AW-1:0] la, input bit fl, input bit inj);
    bit fw;
    cur_fv = fv; cur_fa = fa; cur_lv = lv; cur_la = la; cur_fl = fl;
    f_req_valid = fv; f_req_addr = fa; l_req_valid = lv; l_req_addr = la; flush = fl;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; env_used = 1'b0;
    if (env_q.size() > 0 && env_q[0].due == cyc) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = mem_fn(env_q[0].addr); env_used = 1'b1;
    end else if (inj) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hdead_beef_0bad_f00d;
    end
    fw          = fv && !fl && (starve == SM || !lv);
    e_f_ready   = fw;
    e_l_ready   = lv && !fw;
    e_mem_valid = e_f_ready || e_l_ready;
    e_mem_addr  = e_f_ready ? fa : (e_l_ready ? la : '0);
    due_here    = inflight.size() > 0 && inflight[0].due == cyc;
    e_f_rsp = 1'b0; e_l_rsp = 1'b0; e_f_data = '0; e_l_data = '0;
    if (due_here && mem_rsp_valid) begin
      if (inflight[0].src) begin
        e_l_rsp = 1'b1; e_l_data = mem_fn(inflight[0].addr);
      end else if (!inflight[0].killed && !fl) begin
        e_f_rsp = 1'b1; e_f_data = mem_fn(inflight[0].addr);
      end
    end
    e_busy = inflight.size() > 0;
    #3;
  endtask

  // Commit the cycle to the model and the memory responder, then clock.
  task automatic advance();
    if (cur_fl) foreach (inflight[i]) if (!inflight[i].src) inflight[i].killed = 1'b1;
    if (quiet == 0 && (mem_rsp_valid != due_here)) m_err = 1'b1;
    if (due_here) void'(inflight.pop_front());
    if (env_used) void'(env_q.pop_front());
    quiet = (quiet > 0) ? quiet - 1 : 0;
    if (!cur_fl) starve = (!cur_fv || e_f_ready) ? 0 : ((starve < SM) ? starve + 1 : SM);
    if (e_f_ready) inflight.push_back('{src: 1'b0, addr: cur_fa, due: cyc + LAT, killed: 1'b0});
    else if (e_l_ready) inflight.push_back('{src: 1'b1, addr: cur_la, due: cyc + LAT, killed: 1'b0});
    if (mem_req_valid === 1'b1) env_q.push_back('{due: cyc + LAT, addr: mem_req_addr});
    @(posedge clk); #1; cyc++;
  endtask

  task automatic reset_assert();
    rst_n = 1'b0; flush = 1'b0;
    f_req_valid = 1'b1; f_req_addr = rnd_addr(); l_req_valid = 1'b1; l_req_addr = rnd_addr();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; env_used = 1'b0;
    if (env_q.size() > 0 && env_q[0].due == cyc) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = mem_fn(env_q[0].addr); env_used = 1'b1;
    end
    #3;
  endtask

  task automatic reset_release();
    if (env_used) void'(env_q.pop_front());
    inflight.delete(); starve = 0; m_err = 1'b0; quiet = LAT;
    @(posedge clk); #1; cyc++;
    rst_n = 1'b1; f_req_valid = 1'b0; l_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_assert();
    checks++; if ({f_req_ready, l_req_ready, mem_req_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_ready got=%b exp=000", {f_req_ready, l_req_ready, mem_req_valid}); end
    checks++; if (mem_req_addr !== '0) begin
      failures++; $display("FAIL reset_addr got=%h exp=0", mem_req_addr); end
    checks++; if ({f_rsp_valid, l_rsp_valid, busy, err} !== 4'b0000) begin
      failures++; $display("FAIL reset_status got=%b exp=0000", {f_rsp_valid, l_rsp_valid, busy, err}); end
    reset_release();
  endtask

  task automatic test_f_stream();
    for (int i = 0; i < 6; i++) begin
      tick(i < 3, AW'('h10 + i), 1'b0, '0, 1'b0, 1'b0);
      checks++; if (f_req_ready !== e_f_ready || (i < 3 && f_req_ready !== 1'b1)) begin
        failures++; $display("FAIL fstream_ready i=%0d got=%b exp=%b", i, f_req_ready, e_f_ready); end
      checks++; if (f_rsp_valid !== e_f_rsp || f_rsp_data !== e_f_data) begin
        failures++; $display("FAIL fstream_rsp i=%0d got=%b/%h exp=%b/%h", i, f_rsp_valid, f_rsp_data, e_f_rsp, e_f_data); end
      checks++; if (busy !== e_busy || (i >= 1 && i <= 4 && busy !== 1'b1)) begin
        failures++; $display("FAIL fstream_busy i=%0d got=%b exp=%b", i, busy, e_busy); end
      advance();
    end
  endtask

  task automatic test_starvation();
    logic [7:0] pat = 8'b1000_1000;
    for (int i = 0; i < 11; i++) begin
      tick(i < 8, rnd_addr(), i < 8, rnd_addr(), 1'b0, 1'b0);
      if (i < 8) begin
        checks++; if (f_req_ready !== pat[i] || l_req_ready !== !pat[i]) begin
          failures++; $display("FAIL starve_grant i=%0d got=f%b/l%b exp=f%b", i, f_req_ready, l_req_ready, pat[i]); end
      end
      checks++; if (mem_req_addr !== e_mem_addr) begin
        failures++; $display("FAIL starve_addr i=%0d got=%h exp=%h", i, mem_req_addr, e_mem_addr); end
      checks++; if (f_rsp_valid !== e_f_rsp || l_rsp_valid !== e_l_rsp || f_rsp_data !== e_f_data || l_rsp_data !== e_l_data) begin
        failures++; $display("FAIL starve_rsp i=%0d got=%b%b exp=%b%b", i, f_rsp_valid, l_rsp_valid, e_f_rsp, e_l_rsp); end
      advance();
    end
  endtask

  task automatic test_flush_kill();
    tick(1'b1, AW'('h20), 1'b0, '0, 1'b0, 1'b0); advance();
    tick(1'b0, '0, 1'b1, AW'('h40), 1'b1, 1'b0);
    checks++; if (l_req_ready !== 1'b1 || f_req_ready !== 1'b0) begin
      failures++; $display("FAIL flush_lgrant got=l%b/f%b exp=l1/f0", l_req_ready, f_req_ready); end
    advance();
    tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (f_rsp_valid !== 1'b0 || l_rsp_valid !== 1'b0 || f_rsp_data !== '0) begin
      failures++; $display("FAIL flush_drop got=f%b/l%b exp=f0/l0", f_rsp_valid, l_rsp_valid); end
    advance();
    tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (l_rsp_valid !== 1'b1 || l_rsp_data !== mem_fn(AW'('h40))) begin
      failures++; $display("FAIL flush_lrsp got=%b/%h exp=1/%h", l_rsp_valid, l_rsp_data, mem_fn(AW'('h40))); end
    advance();
    tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (err !== 1'b0) begin
      failures++; $display("FAIL flush_err got=%b exp=0", err); end
    advance();
  endtask

  task automatic test_flush_block();
    tick(1'b1, AW'('h55), 1'b0, '0, 1'b1, 1'b0);
    checks++; if (f_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL flushblk_hold got=%b/%b exp=0/0", f_req_ready, mem_req_valid); end
    advance();
    tick(1'b1, AW'('h55), 1'b0, '0, 1'b0, 1'b0);
    checks++; if (f_req_ready !== 1'b1 || mem_req_addr !== AW'('h55)) begin
      failures++; $display("FAIL flushblk_grant got=%b/%h exp=1/55", f_req_ready, mem_req_addr); end
    advance();
    for (int i = 0; i < LAT + 1; i++) begin
      tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (f_rsp_valid !== e_f_rsp || f_rsp_data !== e_f_data) begin
        failures++; $display("FAIL flushblk_rsp i=%0d got=%b/%h exp=%b/%h", i, f_rsp_valid, f_rsp_data, e_f_rsp, e_f_data); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick(i < 295 && $urandom_range(0, 3) != 0, rnd_addr(), i < 295 && $urandom_range(0, 2) != 0,
           rnd_addr(), $urandom_range(0, 7) == 0, 1'b0);
      checks++; if (f_req_ready !== e_f_ready || l_req_ready !== e_l_ready || mem_req_valid !== e_mem_valid) begin
        failures++; $display("FAIL rand_grant cyc=%0d got=%b%b%b exp=%b%b%b", cyc, f_req_ready, l_req_ready,
                             mem_req_valid, e_f_ready, e_l_ready, e_mem_valid); end
      checks++; if (mem_req_addr !== e_mem_addr) begin
        failures++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, mem_req_addr, e_mem_addr); end
      checks++; if (f_rsp_valid !== e_f_rsp || f_rsp_data !== e_f_data) begin
        failures++; $display("FAIL rand_frsp cyc=%0d got=%b/%h exp=%b/%h", cyc, f_rsp_valid, f_rsp_data, e_f_rsp, e_f_data); end
      checks++; if (l_rsp_valid !== e_l_rsp || l_rsp_data !== e_l_data) begin
        failures++; $display("FAIL rand_lrsp cyc=%0d got=%b/%h exp=%b/%h", cyc, l_rsp_valid, l_rsp_data, e_l_rsp, e_l_data); end
      checks++; if (busy !== e_busy || err !== m_err) begin
        failures++; $display("FAIL rand_status cyc=%0d got=b%b/e%b exp=b%b/e%b", cyc, busy, err, e_busy, m_err); end
      advance();
    end
  endtask

  task automatic test_spurious();
    tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (f_rsp_valid !== 1'b0 || l_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL spur_rsp got=f%b/l%b exp=f0/l0", f_rsp_valid, l_rsp_valid); end
    advance();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (err !== 1'b1 || err !== m_err) begin
        failures++; $display("FAIL spur_err i=%0d got=%b exp=1", i, err); end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, AW'('h70), 1'b0, '0, 1'b0, 1'b0); advance();
    tick(1'b1, AW'('h71), 1'b0, '0, 1'b0, 1'b0); advance();
    reset_assert();
    checks++; if ({f_req_ready, l_req_ready, mem_req_valid, f_rsp_valid, l_rsp_valid, busy, err} !== 7'b0) begin
      failures++; $display("FAIL midrst_outs got=%b exp=0000000",
                           {f_req_ready, l_req_ready, mem_req_valid, f_rsp_valid, l_rsp_valid, busy, err}); end
    reset_release();
    for (int i = 0; i < 6; i++) begin
      tick(i == 2, AW'('h99), 1'b0, '0, 1'b0, 1'b0);
      if (i == 0) begin
        checks++; if (mem_rsp_valid !== 1'b1 || f_rsp_valid !== 1'b0) begin
          failures++; $display("FAIL midrst_stale got=%b exp=0", f_rsp_valid); end
      end
      if (i == 2) begin
        checks++; if (f_req_ready !== 1'b1) begin
          failures++; $display("FAIL midrst_grant got=%b exp=1", f_req_ready); end
      end
      if (i == 4) begin
        checks++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== mem_fn(AW'('h99))) begin
          failures++; $display("FAIL midrst_rsp got=%b/%h exp=1/%h", f_rsp_valid, f_rsp_data, mem_fn(AW'('h99))); end
      end
      checks++; if (err !== 1'b0) begin
        failures++; $display("FAIL midrst_err i=%0d got=%b exp=0", i, err); end
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; f_req_valid = 1'b0; l_req_valid = 1'b0;
    f_req_addr = '0; l_req_addr = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #1;
    test_reset();
    test_f_stream();
    test_starvation();
    test_flush_kill();
    test_flush_block();
    test_random();
    test_spurious();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
